// File: rtl/cache_block_serializer.sv
// Splits one cache-block Wishbone request into BEATS consecutive memory-bus beats.
// Define SKIP_EMPTY_BEAT_EN to drop write beats whose byte-enable slice is all zero.
module cache_block_serializer #(
    parameter int BLOCK_SIZE = 128,
    parameter int DATA_SIZE  = 32,
    parameter int ADDR_SIZE  = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    s_cyc,
    input  logic                    s_stb,
    input  logic                    s_we,
    input  logic [ADDR_SIZE-1:0]    s_addr,
    input  logic [BLOCK_SIZE-1:0]   s_dat_i,
    input  logic [BLOCK_SIZE/8-1:0] s_sel,
    output logic [BLOCK_SIZE-1:0]   s_dat_o,
    output logic                    s_ack,
    output logic                    m_cyc,
    output logic                    m_stb,
    output logic                    m_we,
    output logic [ADDR_SIZE-1:0]    m_addr,
    output logic [DATA_SIZE/8-1:0]  m_sel,
    output logic [DATA_SIZE-1:0]    m_dat_o,
    input  logic [DATA_SIZE-1:0]    m_dat_i,
    input  logic                    m_ack
);

    localparam int BEATS      = BLOCK_SIZE / DATA_SIZE;
    localparam int BEAT_BYTES = DATA_SIZE / 8;
    localparam int SEL_W      = BLOCK_SIZE / 8;
    localparam int CNT_W      = $clog2(BEATS);
    localparam logic [ADDR_SIZE-1:0] OFF_MASK = ADDR_SIZE'(SEL_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        BEAT,
        DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BLOCK_SIZE-1:0]   rbuf_q;
    logic [ADDR_SIZE-1:0]    base_q;
    logic                    we_q;
    logic [BLOCK_SIZE-1:0]   data_q;
    logic [SEL_W-1:0]        sel_q;
    logic                    capture;
    logic                    rd_store;

`ifdef SKIP_EMPTY_BEAT_EN
    logic [CNT_W:0]          nb;

    // Lowest beat index >= start with a non-empty sel slice; MSB flags a hit.
    function automatic logic [CNT_W:0] next_beat(input logic [SEL_W-1:0] sel, input int start);
        logic [CNT_W:0] r;
        r = '0;
        for (int i = BEATS - 1; i >= 0; i--) begin
            if (i >= start && (|sel[i*BEAT_BYTES +: BEAT_BYTES])) begin
                r = {1'b1, CNT_W'(i)};
            end
        end
        return r;
    endfunction
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        capture  = 1'b0;
        rd_store = 1'b0;
        s_ack    = 1'b0;
        m_cyc    = 1'b0;
        m_stb    = 1'b0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_sel    = '0;
        m_dat_o  = '0;
`ifdef SKIP_EMPTY_BEAT_EN
        nb       = '0;
`endif
        case (state_q)
            IDLE: begin
                if (s_cyc && s_stb) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = BEAT;
`ifdef SKIP_EMPTY_BEAT_EN
                    if (s_we) begin
                        nb = next_beat(s_sel, 0);
                        if (nb[CNT_W]) cnt_d = nb[CNT_W-1:0];
                        else           state_d = DONE;
                    end
`endif
                end
            end
            BEAT: begin
                m_cyc   = 1'b1;
                m_stb   = 1'b1;
                m_we    = we_q;
                m_addr  = base_q + ADDR_SIZE'(cnt_q) * ADDR_SIZE'(BEAT_BYTES);
                m_dat_o = data_q[cnt_q*DATA_SIZE +: DATA_SIZE];
                m_sel   = we_q ? sel_q[cnt_q*BEAT_BYTES +: BEAT_BYTES] : '1;
                if (m_ack) begin
                    rd_store = !we_q;
                    if (cnt_q == CNT_W'(BEATS - 1)) state_d = DONE;
                    else                            cnt_d   = cnt_q + 1'b1;
`ifdef SKIP_EMPTY_BEAT_EN
                    if (we_q) begin
                        nb = next_beat(sel_q, int'(cnt_q) + 1);
                        if (nb[CNT_W]) cnt_d = nb[CNT_W-1:0];
                        else           state_d = DONE;
                    end
`endif
                end
            end
            DONE: begin
                s_ack   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (rd_store) rbuf_q[cnt_q*DATA_SIZE +: DATA_SIZE] <= m_dat_i;
        end
    end

    // Request payload is only observed while in BEAT, so it needs no reset.
    always_ff @(posedge clock) begin
        if (capture) begin
            base_q <= s_addr & ~OFF_MASK;
            we_q   <= s_we;
            data_q <= s_dat_i;
            sel_q  <= s_sel;
        end
    end

    assign s_dat_o = rbuf_q;

endmodule

// File: tb/tb_cache_block_serializer.sv
// Bench for cache_block_serializer: vector table plus reset/spurious-ack sequences.
// Expected beats are queued at request time and checked as the memory side acks them.
module tb_cache_block_serializer;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         s_cyc = 1'b0, s_stb = 1'b0, s_we = 1'b0;
    logic [31:0]  s_addr = '0;
    logic [127:0] s_dat_i = '0;
    logic [15:0]  s_sel = '0;
    logic [127:0] s_dat_o;
    logic         s_ack;
    logic         m_cyc, m_stb, m_we;
    logic [31:0]  m_addr;
    logic [3:0]   m_sel;
    logic [31:0]  m_dat_o;
    logic [31:0]  m_dat_i;
    logic         m_ack;

    int n_checks = 0;
    int n_fail = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    logic ack_force = 1'b0;
    logic [127:0] model_rd = '0;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } beat_t;
    beat_t bq[$];
    beat_t mon_e;
    logic        stall_v = 1'b0;
    logic [31:0] stall_addr = '0;

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [127:0] dat;
        logic [15:0]  sel;
        logic [127:0] exp_rd;
        int           ack_dly;
        bit           hold;
    } vec_t;
    vec_t vecs[7];

    cache_block_serializer #(.BLOCK_SIZE(128), .DATA_SIZE(32), .ADDR_SIZE(32)) dut (
        .clock(clk), .reset(reset),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr),
        .s_dat_i(s_dat_i), .s_sel(s_sel), .s_dat_o(s_dat_o), .s_ack(s_ack),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr),
        .m_sel(m_sel), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_ack(m_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a[31:12] == 20'h00001) return 32'hA0 + {28'd0, a[3:2]};
        return a ^ 32'h5A5A_0000;
    endfunction

    assign m_dat_i = memf(m_addr);
    assign m_ack   = ack_force | (m_stb && (wait_cnt == ack_delay));

    always @(posedge clk) wait_cnt <= (m_stb && !m_ack) ? wait_cnt + 1 : 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory-side monitor: every acknowledged beat must match the head of the queue.
    always @(negedge clk) begin
        if (reset && m_stb && m_ack) begin
            n_checks++;
            if (bq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got addr %h expected no beat", m_addr);
            end else begin
                mon_e = bq.pop_front();
                chk("beat_addr", m_addr, mon_e.addr);
                chk("beat_we", m_we, mon_e.we);
                chk("beat_sel", m_sel, mon_e.sel);
                chk("beat_cyc", m_cyc, 1'b1);
                if (mon_e.we) chk("beat_dat", m_dat_o, mon_e.dat);
            end
        end
        if (reset && m_stb && stall_v) chk("stall_addr", m_addr, stall_addr);
        stall_v    <= reset && m_stb && !m_ack;
        stall_addr <= m_addr;
    end

    task automatic do_req(input vec_t v);
        int nb;
        int lat;
        bit got;
        logic [3:0] s;
        beat_t e;
        logic [127:0] exp_dat;
        ack_delay = v.ack_dly;
        nb = 0;
        for (int b = 0; b < 4; b++) begin
            s = v.sel[b*4 +: 4];
`ifdef SKIP_EMPTY_BEAT_EN
            if (v.we && s == 4'h0) continue;
`endif
            e.addr = (v.addr & ~32'hF) + 32'(b * 4);
            e.we   = v.we;
            e.sel  = v.we ? s : 4'hF;
            e.dat  = v.dat[b*32 +: 32];
            bq.push_back(e);
            nb++;
        end
        if (!v.we) model_rd = v.exp_rd;
        exp_dat = model_rd;
        @(negedge clk);
        s_cyc = 1'b1; s_stb = 1'b1; s_we = v.we;
        s_addr = v.addr; s_dat_i = v.dat; s_sel = v.sel;
        lat = 0;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(posedge clk); #1;
            lat++;
            if (!v.hold) begin
                s_cyc = 1'b0; s_stb = 1'b0;
            end else begin
                s_addr = v.addr ^ 32'h0000_0F00; s_we = !v.we; s_sel = ~v.sel;
            end
            if (s_ack) got = 1'b1;
        end
        s_cyc = 1'b0; s_stb = 1'b0;
        chk("s_ack_seen", got, 1'b1);
        chk("latency", lat, nb * (v.ack_dly + 1) + 1);
        chk("s_dat_o", s_dat_o, exp_dat);
        chk("beats_left", bq.size(), 0);
        @(posedge clk); #1;
        chk("s_ack_pulse", s_ack, 1'b0);
        chk("idle_after", m_cyc, 1'b0);
    endtask

    initial begin
        vecs[0] = '{we: 1'b0, addr: 32'h1004, dat: '0, sel: 16'h0000,
                    exp_rd: 128'h000000A3_000000A2_000000A1_000000A0, ack_dly: 0, hold: 1'b0};
        vecs[1] = '{we: 1'b1, addr: 32'h2000, dat: 128'h44443333_22221111_DDDDCCCC_BBBBAAAA,
                    sel: 16'hFFFF, exp_rd: '0, ack_dly: 0, hold: 1'b0};
        vecs[2] = '{we: 1'b0, addr: 32'h3008, dat: '0, sel: 16'h0000,
                    exp_rd: 128'h5A5A300C_5A5A3008_5A5A3004_5A5A3000, ack_dly: 3, hold: 1'b0};
        vecs[3] = '{we: 1'b1, addr: 32'h2010, dat: 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000,
                    sel: 16'h00F0, exp_rd: '0, ack_dly: 0, hold: 1'b0};
        vecs[4] = '{we: 1'b1, addr: 32'h4000, dat: 128'h12345678_9ABCDEF0_0FEDCBA9_87654321,
                    sel: 16'h0000, exp_rd: '0, ack_dly: 0, hold: 1'b0};
        vecs[5] = '{we: 1'b1, addr: 32'h5004, dat: 128'h76543210_FEDCBA98_01234567_89ABCDEF,
                    sel: 16'h0F3C, exp_rd: '0, ack_dly: 1, hold: 1'b0};
        vecs[6] = '{we: 1'b0, addr: 32'h100C, dat: '0, sel: 16'h0000,
                    exp_rd: 128'h000000A3_000000A2_000000A1_000000A0, ack_dly: 2, hold: 1'b1};

        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ack", s_ack, 1'b0);
        chk("rst_m_cyc", m_cyc, 1'b0);
        chk("rst_m_stb", m_stb, 1'b0);
        chk("rst_m_addr", m_addr, 32'h0);
        chk("rst_s_dat_o", s_dat_o, 128'h0);
        @(negedge clk) reset = 1'b1;

        for (int i = 0; i < 7; i++) do_req(vecs[i]);

        // Spurious memory acks while idle must not start anything.
        @(negedge clk) ack_force = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("spur_m_cyc", m_cyc, 1'b0);
            chk("spur_s_ack", s_ack, 1'b0);
            chk("spur_s_dat_o", s_dat_o, model_rd);
        end
        @(negedge clk) ack_force = 1'b0;

        // Reset asserted during beat 2 of a read.
        ack_delay = 0;
        for (int b = 0; b < 4; b++) begin
            mon_e.addr = 32'h3000 + 32'(b * 4);
            mon_e.we = 1'b0; mon_e.sel = 4'hF; mon_e.dat = '0;
            bq.push_back(mon_e);
        end
        @(negedge clk);
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_addr = 32'h3000; s_sel = '0;
        @(posedge clk); #1;
        s_cyc = 1'b0; s_stb = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("beat2_addr", m_addr, 32'h3008);
        reset = 1'b0;
        #1;
        chk("mid_rst_m_cyc", m_cyc, 1'b0);
        chk("mid_rst_m_stb", m_stb, 1'b0);
        chk("mid_rst_s_ack", s_ack, 1'b0);
        chk("mid_rst_m_addr", m_addr, 32'h0);
        chk("mid_rst_m_sel", m_sel, 4'h0);
        chk("mid_rst_s_dat_o", s_dat_o, 128'h0);
        bq.delete();
        model_rd = '0;
        @(negedge clk) reset = 1'b1;
        do_req(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
